weight_buffer_writer: RTL and testbench

Loads a convolution weight tensor from a DDR read stream into the N_BUF_X banked weight buffers that `weight_buffer_reader` later reads. It sits directly upstream of the reader. It accepts one DATA_WIDTH word per beat on an AXI-Stream slave and steers each word to bank `x % N_BUF_X`. The in-bank address follows the layout the reader expects: `n_wrap_c*(y + h_wei*floor(x/N_BUF_X)) + k`.

---
 rtl/weight_buffer_writer_pkg.sv | 21 ++
 rtl/weight_buffer_writer_if.sv | 14 +
 rtl/weight_buffer_writer_addr_gen.sv | 59 +++++
 rtl/weight_buffer_writer.sv | 110 +++++++++++
 tb/tb_weight_buffer_writer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_buffer_writer_pkg.sv
// Shared definitions for the weight buffer writer/reader pair: shape field
// layout, channel chunking and FSM state encoding.
package weight_buf_pkg;

  localparam int unsigned C_LSB       = 0;
  localparam int unsigned H_LSB       = 16;
  localparam int unsigned W_LSB       = 32;
  localparam int unsigned FIELD_W     = 16;
  localparam int unsigned CHUNK_SHIFT = 6;
  // Wide enough for the full h * n_wrap_c product
  localparam int unsigned OFF_W       = 2 * FIELD_W - CHUNK_SHIFT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [FIELD_W-1:0] n_wrap_c(input logic [FIELD_W-1:0] c);
    return c >> CHUNK_SHIFT;
  endfunction

endpackage

// File: rtl/weight_buffer_writer_if.sv
// AXI-Stream weight word channel feeding the weight buffer writer.
interface weight_buffer_writer_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/weight_buffer_writer_addr_gen.sv
// Bank/address walker for the weight buffer writer: steps k,y inside a column
// via off_r, rotates banks via rx_r and bumps the column base every N_BUF_X columns.
module wbw_addr_gen
  import weight_buf_pkg::*;
#(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int BX_W       = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init,
  input  logic                  adv,
  input  logic [OFF_W-1:0]      hn,
  input  logic [FIELD_W-1:0]    w_m1,
  output logic [BX_W-1:0]       bank,
  output logic [B_BUF_ADDR-1:0] addr,
  output logic                  last
);

  logic [OFF_W-1:0]      off_r;
  logic [BX_W-1:0]       rx_r;
  logic [B_BUF_ADDR-1:0] base_r;
  logic [FIELD_W-1:0]    col_r;
  logic                  off_wrap;

  assign off_wrap = (off_r == hn - OFF_W'(1));
  assign last     = off_wrap && (col_r == w_m1);
  assign bank     = rx_r;
  assign addr     = base_r + off_r[B_BUF_ADDR-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      off_r  <= '0;
      rx_r   <= '0;
      base_r <= '0;
      col_r  <= '0;
    end else if (init) begin
      off_r  <= '0;
      rx_r   <= '0;
      base_r <= '0;
      col_r  <= '0;
    end else if (adv) begin
      if (off_wrap) begin
        off_r <= '0;
        col_r <= col_r + FIELD_W'(1);
        if (rx_r == BX_W'(N_BUF_X - 1)) begin
          rx_r   <= '0;
          base_r <= base_r + hn[B_BUF_ADDR-1:0];
        end else begin
          rx_r <= rx_r + BX_W'(1);
        end
      end else begin
        off_r <= off_r + OFF_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_buffer_writer.sv
// Streams a weight tensor into N_BUF_X interleaved banks in reader layout.
// Optional WEIGHT_BUFFER_WRITER_TLAST_CHECK_EN flags tlast/last-word disagreement in err.
module weight_buffer_writer
  import weight_buf_pkg::*;
#(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 48,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [B_SHAPE-1:0]             wei_shape,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  weight_buffer_writer_if.slave          s_axis,
  output logic [N_BUF_X-1:0]             wren,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
  output logic [DATA_WIDTH-1:0]          wrdata
);

  localparam int BX_W = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;

  logic [1:0]            state_r;
  logic [OFF_W-1:0]      hn_r;
  logic [FIELD_W-1:0]    w_m1_r;
  logic [FIELD_W-1:0]    c_in, h_in, w_in;
  logic [OFF_W-1:0]      hn_next;
  logic                  degenerate;
  logic                  start_acc;
  logic                  beat;
  logic [BX_W-1:0]       bank;
  logic [B_BUF_ADDR-1:0] addr;
  logic                  last;

  assign c_in = wei_shape[C_LSB +: FIELD_W];
  assign h_in = wei_shape[H_LSB +: FIELD_W];
  assign w_in = wei_shape[W_LSB +: FIELD_W];

  // Only multiply in the block; done once per load when start is taken
  assign hn_next    = OFF_W'(h_in) * OFF_W'(n_wrap_c(c_in));
  assign degenerate = (c_in < FIELD_W'(64)) || (h_in == '0) || (w_in == '0);

  assign start_acc     = start && (state_r == ST_IDLE);
  assign s_axis.tready = (state_r == ST_LOAD);
  assign beat          = s_axis.tvalid && s_axis.tready;
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);

  wbw_addr_gen #(
    .N_BUF_X    (N_BUF_X),
    .B_BUF_ADDR (B_BUF_ADDR),
    .BX_W       (BX_W)
  ) u_addr_gen (
    .clk  (clk),
    .rstn (rstn),
    .init (start_acc),
    .adv  (beat),
    .hn   (hn_r),
    .w_m1 (w_m1_r),
    .bank (bank),
    .addr (addr),
    .last (last)
  );

`ifndef WEIGHT_BUFFER_WRITER_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      hn_r    <= '0;
      w_m1_r  <= '0;
      err     <= 1'b0;
      wren    <= '0;
      wraddr  <= '0;
      wrdata  <= '0;
    end else begin
      wren <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            hn_r    <= hn_next;
            w_m1_r  <= w_in - FIELD_W'(1);
            err     <= degenerate;
            state_r <= degenerate ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            wren   <= N_BUF_X'(1) << bank;
            wraddr <= {N_BUF_X{addr}};
            wrdata <= s_axis.tdata;
`ifdef WEIGHT_BUFFER_WRITER_TLAST_CHECK_EN
            if (s_axis.tlast != last) err <= 1'b1;
`endif
            if (last) state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Scoreboard bench for weight_buffer_writer: expected bank writes are queued
// as beats are accepted and popped when wren appears.
module tb_weight_buffer_writer;

  localparam int N  = 5;
  localparam int BA = 9;
  localparam int BS = 48;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [BS-1:0]   wei_shape = '0;
  logic            start = 1'b0;
  logic            busy, done, err;
  logic [N-1:0]    wren;
  logic [BA*N-1:0] wraddr;
  logic [DW-1:0]   wrdata;

  weight_buffer_writer_if #(.DATA_WIDTH(DW)) s_axis ();

  weight_buffer_writer #(
    .N_BUF_X    (N),
    .B_BUF_ADDR (BA),
    .B_SHAPE    (BS),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wei_shape (wei_shape),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .s_axis    (s_axis),
    .wren      (wren),
    .wraddr    (wraddr),
    .wrdata    (wrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            bank;
    int            addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic acc_q;

  function automatic logic [DW-1:0] word_of(input int idx, input int tag);
    logic [31:0] a, b;
    a = 32'(idx) * 32'h9E3779B9 + 32'd1;
    b = {tag[15:0], idx[15:0]};
    return {b, a};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= 1'b0;
    else       acc_q <= s_axis.tvalid && s_axis.tready;
  end

  // Write-side monitor: every write must follow an accepted beat and match the queue head
  always @(negedge clk) begin
    if (rstn) begin
      if (wren !== '0) begin
        checks++;
        if (acc_q !== 1'b1) begin
          errors++;
          $display("FAIL wren_without_beat wren=%b acc=%b required acc=1", wren, acc_q);
        end
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write wren=%b addr=%h required no write", wren, wraddr);
        end else begin
          exp_t e;
          logic [N-1:0]  ew;
          logic [BA-1:0] ga;
          e  = sb.pop_front();
          ew = N'(1) << e.bank;
          ga = wraddr[e.bank*BA +: BA];
          checks++;
          if (wren !== ew || ga !== BA'(e.addr) || wrdata !== e.data) begin
            errors++;
            $display("FAIL write wren=%b addr=%0d data=%h required wren=%b addr=%0d data=%h",
                     wren, ga, wrdata, ew, e.addr, e.data);
          end
        end
      end else if (acc_q === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL missing_write wren=%b required a write after accepted beat", wren);
      end
    end
  end

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
  end

  task automatic pulse_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    s_axis.tvalid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1;
    sb.delete();
  endtask

  task automatic run_load(input string name, input int c, input int h, input int w,
                          input int pct, input int tlast_at, input int start_at,
                          input int rst_at, input logic exp_err, input int tag);
    int   n, t, idx, cyc, x, y, k;
    logic v;
    exp_t e;
    n = c >> 6;
    t = w * h * n;
    @(negedge clk);
    wei_shape = {16'(w), 16'(h), 16'(c)};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (s_axis.tready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start tready=%b busy=%b required 1 1", name, s_axis.tready, busy);
    end
    idx = 0;
    cyc = 0;
    while (idx < t && cyc < t * 40 + 50) begin
      v = ($urandom_range(99) < pct);
      start = (idx == start_at);
      s_axis.tvalid = v;
      s_axis.tdata  = word_of(idx, tag);
      s_axis.tlast  = (idx == tlast_at);
      if (v && s_axis.tready === 1'b1) begin
        k = idx % n;
        y = (idx / n) % h;
        x = idx / (n * h);
        e.bank = x % N;
        e.addr = (n * (y + h * (x / N)) + k) % (1 << BA);
        e.data = word_of(idx, tag);
        sb.push_back(e);
        idx++;
      end
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (idx < t) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s_early_done done=%b after %0d beats required 0", name, done, idx);
        end
      end
      if (rst_at >= 0 && idx == rst_at) begin
        #2 rstn = 1'b0;
        s_axis.tvalid = 1'b0;
        #1;
        checks++;
        if (wren !== '0 || s_axis.tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_async_reset wren=%b tready=%b busy=%b done=%b required 0 0 0 0",
                   name, wren, s_axis.tready, busy, done);
        end
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL %s_pending_before_reset pending=%0d required 0", name, sb.size());
        end
        @(negedge clk);
        #1 rstn = 1'b1;
        sb.delete();
        return;
      end
    end
    if (idx < t) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout beats=%0d required %0d", name, idx, t);
      pulse_reset();
      return;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || s_axis.tready !== 1'b0 || err !== exp_err) begin
      errors++;
      $display("FAIL %s_done done=%b busy=%b tready=%b err=%b required 1 1 0 %b",
               name, done, busy, s_axis.tready, err, exp_err);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_idle done=%b busy=%b pending=%0d required 0 0 0",
               name, done, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || s_axis.tready !== 1'b0 ||
        wren !== '0 || wraddr !== '0 || wrdata !== '0) begin
      errors++;
      $display("FAIL reset_values busy=%b done=%b err=%b tready=%b wren=%b wraddr=%h wrdata=%h required all 0",
               busy, done, err, s_axis.tready, wren, wraddr, wrdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_axis.tready !== 1'b0 || wren !== '0) begin
      errors++;
      $display("FAIL post_reset busy=%b tready=%b wren=%b required 0 0 0", busy, s_axis.tready, wren);
    end
  endtask

  task automatic test_degenerate(input string name, input int c, input int h, input int w);
    @(negedge clk);
    wei_shape = {16'(w), 16'(h), 16'(c)};
    start = 1'b1;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || s_axis.tready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_done done=%b err=%b tready=%b busy=%b required 1 1 0 1",
               name, done, err, s_axis.tready, busy);
    end
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL %s_after done=%b busy=%b err=%b required 0 0 1", name, done, busy, err);
    end
  endtask

  task automatic test_basic();
    run_load("basic", 128, 3, 7, 100, 41, -1, -1, 1'b0, 1);
  endtask

  task automatic test_backpressure();
    run_load("backpressure", 128, 3, 7, 55, 41, -1, -1, 1'b0, 2);
  endtask

  task automatic test_single();
    run_load("single", 64, 1, 1, 100, 0, -1, -1, 1'b0, 3);
  endtask

  task automatic test_tlast_mismatch();
    logic exp_err;
`ifdef WEIGHT_BUFFER_WRITER_TLAST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_load("tlast", 128, 3, 7, 100, 19, -1, -1, exp_err, 4);
  endtask

  task automatic test_reset_mid_load();
    run_load("midreset", 128, 3, 7, 100, 41, -1, 10, 1'b0, 5);
    run_load("reload", 128, 3, 7, 80, 41, -1, -1, 1'b0, 6);
  endtask

  task automatic test_start_during_load();
    run_load("start_in_load", 192, 2, 6, 100, 35, 15, -1, 1'b0, 7);
  endtask

  task automatic test_wide_shape();
    run_load("wide", 64, 4, 11, 70, 43, -1, -1, 1'b0, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate("degen_c", 32, 1, 1);
    test_single();
    test_degenerate("degen_h", 128, 0, 4);
    test_tlast_mismatch();
    test_reset_mid_load();
    test_start_during_load();
    test_wide_shape();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
